// File: rtl/ds_dac_dig.sv
// ds_dac_dig - digital half of a first-order delta-sigma DAC.
//
// Signed PCM words enter through a valid/ready handshake into a 2-entry
// FIFO. Each word is held for OVERSAMP_RATIO clock cycles (one frame) in the
// active-sample register. A first-order error-feedback modulator turns the
// active sample into a 1-bit density stream.
//
// Ports:
//   clk            oversampling clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   din            signed PCM sample (WIDTH bits)
//   din_valid      din carries a word
//   din_ready      FIFO has a free slot (registered, independent of din_valid)
//   bit_out        modulator bitstream, 1 = +FS, 0 = -FS
//   sample_strobe  one-cycle pulse in the cycle after each frame reload
//   underrun       one-cycle pulse, aligned with sample_strobe, when the
//                  reload found the FIFO empty and the old sample was kept
module ds_dac_dig #(
    parameter int WIDTH          = 8,
    parameter int OVERSAMP_RATIO = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic                    bit_out,
    output logic                    sample_strobe,
    output logic                    underrun
);

    localparam int CNT_W  = $clog2(OVERSAMP_RATIO);
    // Two guard bits: the loop keeps |acc| <= 2*FS for any in-range input.
    localparam int ACC_W  = WIDTH + 2;
    localparam int FS_INT = 1 << (WIDTH - 1);

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(OVERSAMP_RATIO - 1);
    localparam logic signed [ACC_W-1:0] FS_POS   = ACC_W'(FS_INT);
    localparam logic signed [ACC_W-1:0] FS_NEG   = -ACC_W'(FS_INT);

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [WIDTH-1:0] s);
        return {{(ACC_W - WIDTH){s[WIDTH-1]}}, s};
    endfunction

    // Frame counter and FIFO state
    logic [CNT_W-1:0]        r_ovs_cnt;
    logic signed [WIDTH-1:0] r_mem [2];
    logic                    r_rd_ptr;
    logic                    r_wr_ptr;
    logic [1:0]              r_count;
    logic                    r_ready;

    // Modulator state
    logic signed [WIDTH-1:0] r_sample;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_bit;
    logic                    r_strobe;
    logic                    r_underrun;

    logic                    w_reload;
    logic                    w_push;
    logic                    w_pop;
    logic [1:0]              w_count_next;
    logic signed [ACC_W-1:0] w_fb;
    logic signed [ACC_W-1:0] w_acc_next;

    assign w_reload = (r_ovs_cnt == CNT_LAST);
    assign w_push   = din_valid && r_ready;
    // Pop decision uses the count before this cycle's push, so a word pushed
    // in the reload cycle of an empty FIFO waits for the next frame.
    assign w_pop    = w_reload && (r_count != 2'd0);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 2'd1;
        end
    end

    assign w_fb       = r_bit ? FS_POS : FS_NEG;
    assign w_acc_next = r_acc + sext(r_sample) - w_fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovs_cnt  <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_ready    <= 1'b1;
            r_sample   <= '0;
            r_acc      <= '0;
            r_bit      <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_ovs_cnt  <= w_reload ? '0 : r_ovs_cnt + CNT_W'(1);
            r_count    <= w_count_next;
            // Ready is registered from the next count so din_valid never
            // reaches din_ready combinationally.
            r_ready    <= (w_count_next != 2'd2);
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_sample <= r_mem[r_rd_ptr];
            end
            r_acc      <= w_acc_next;
            r_bit      <= !w_acc_next[ACC_W-1];
            r_strobe   <= w_reload;
            r_underrun <= w_reload && (r_count == 2'd0);
        end
    end

    // FIFO storage carries data only; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign din_ready     = r_ready;
    assign bit_out       = r_bit;
    assign sample_strobe = r_strobe;
    assign underrun      = r_underrun;

endmodule
